memory_responder: RTL



---
 rtl/mem_pkg.sv | 27 ++
 rtl/memory_responder_if.sv | 44 ++++
 rtl/memory_array.sv | 22 ++
 rtl/memory_responder.sv | 117 +++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory responder.
// Holds FSM encoding, operation kind and wait-counter sizing.
package mem_pkg;

    localparam int ADDR_W_DEF      = 8;
    localparam int DATA_W_DEF      = 16;
    localparam int WAIT_STATES_DEF = 2;
    localparam int CNT_W           = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_DONE
    } state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_t;

    // Counter reload value; zero when no wait cycles are configured.
    function automatic logic [CNT_W-1:0] wait_load(input int ws);
        return (ws > 0) ? CNT_W'(ws - 1) : '0;
    endfunction

endpackage

// File: rtl/memory_responder_if.sv
// Request/response bus between a requester and the memory responder.
// The master drives requests; the slave answers with status and data.
interface memory_responder_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic [ADDR_W-1:0] MEM_addr;
    logic [DATA_W-1:0] MEM_data_in;
    logic              MEM_rd_req;
    logic              MEM_wr_req;
    logic              MEM_ready;
    logic              MEM_busy;
    logic              MEM_done;
    logic [DATA_W-1:0] MEM_data_out;
    logic              MEM_err;

    modport master (
        output MEM_addr,
        output MEM_data_in,
        output MEM_rd_req,
        output MEM_wr_req,
        input  MEM_ready,
        input  MEM_busy,
        input  MEM_done,
        input  MEM_data_out,
        input  MEM_err
    );

    modport slave (
        input  MEM_addr,
        input  MEM_data_in,
        input  MEM_rd_req,
        input  MEM_wr_req,
        output MEM_ready,
        output MEM_busy,
        output MEM_done,
        output MEM_data_out,
        output MEM_err
    );

endinterface

// File: rtl/memory_array.sv
// Single-port word storage: synchronous write, registered read, no reset.
module memory_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
        rd_data <= mem[addr];
    end

endmodule

// File: rtl/memory_responder.sv
// Wait-state memory responder: latches one request, stalls, accesses,
// then pulses done. Outputs are registered alongside the FSM state.
module memory_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WAIT_STATES = WAIT_STATES_DEF
) (
    input  logic               MEM_clk,
    input  logic               MEM_rst,
    memory_responder_if.slave  bus
);

    localparam bit              HAS_WAIT = (WAIT_STATES > 0);
    localparam logic [CNT_W-1:0] CNT_LOAD = wait_load(WAIT_STATES);

    state_t            state;
    op_t               op;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  cnt;

    logic              ready;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] data_out;

    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] arr_addr;
    logic              arr_we;
    logic [DATA_W-1:0] arr_rd_data;

    assign rd = bus.MEM_rd_req;
    assign wr = bus.MEM_wr_req;

    // In IDLE the array looks at the live address so a zero-wait read
    // already has its word registered when ACCESS begins.
    assign arr_addr = (state == ST_IDLE) ? bus.MEM_addr : addr_q;
    assign arr_we   = (state == ST_ACCESS) && (op == OP_WR) && !MEM_rst;

    memory_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk     (MEM_clk),
        .we      (arr_we),
        .addr    (arr_addr),
        .wr_data (data_q),
        .rd_data (arr_rd_data)
    );

    always_ff @(posedge MEM_clk) begin
        if (MEM_rst) begin
            state    <= ST_IDLE;
            op       <= OP_RD;
            addr_q   <= '0;
            data_q   <= '0;
            cnt      <= '0;
            ready    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            data_out <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (rd ^ wr) begin
                        op     <= wr ? OP_WR : OP_RD;
                        addr_q <= bus.MEM_addr;
                        data_q <= bus.MEM_data_in;
                        ready  <= 1'b0;
                        busy   <= 1'b1;
                        if (HAS_WAIT) begin
                            state <= ST_WAIT;
                            cnt   <= CNT_LOAD;
                        end else begin
                            state <= ST_ACCESS;
                        end
                    end else if (rd && wr) begin
                        err <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state <= ST_ACCESS;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_ACCESS: begin
                    if (op == OP_RD) begin
                        data_out <= arr_rd_data;
                    end
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.MEM_ready    = ready;
    assign bus.MEM_busy     = busy;
    assign bus.MEM_done     = done;
    assign bus.MEM_err      = err;
    assign bus.MEM_data_out = data_out;

endmodule
